// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin arbiter picks one operation at a time. The operands are held
// in registers that drive the ALU for SETTLE cycles. The result is then
// normalised and returned to the granted requester over a valid/ready
// response handshake.
module alu_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_dz,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  // The counter counts down to zero, so it is loaded with SETTLE-1.
  // A zero counter means the result is captured on the next edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        dz_q, dz_d;

  logic        win_id;
  logic        win_any;
  logic        accept;
  logic        rsp_done;
  logic [7:0]  sel_a, sel_b;
  logic [1:0]  sel_op;
  logic [15:0] norm_result;
  logic        norm_dz;

  // Round-robin winner: a lone requester wins; on a tie the requester that
  // did not get the last grant wins.
  always_comb begin
    win_any = |req_valid;
    case (req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_grant_q;
      default: win_id = 1'b0;
    endcase
  end

  // Only the winner sees ready, and only while idle and out of reset.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == S_IDLE && !rst && win_any) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    if (win_id) begin
      sel_a  = req_a[15:8];
      sel_b  = req_b[15:8];
      sel_op = req_op[3:2];
    end else begin
      sel_a  = req_a[7:0];
      sel_b  = req_b[7:0];
      sel_op = req_op[1:0];
    end
  end

  assign accept   = (state_q == S_IDLE) && |(req_valid & req_ready);
  assign rsp_done = (state_q == S_RESP) && rsp_ready[grant_id_q];

  // Result normalisation. For sub the ALU only guarantees the low byte, so
  // that byte is sign-extended. A divide by zero returns zero, whatever the
  // ALU produced.
  always_comb begin
    norm_dz     = (op_q == OP_DIV) && (b_q == 8'd0);
    norm_result = alu_result;
    if (op_q == OP_SUB) begin
      norm_result = {{8{alu_result[7]}}, alu_result[7:0]};
    end else if (norm_dz) begin
      norm_result = 16'h0000;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    dz_d         = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d        = sel_a;
          b_d        = sel_b;
          op_d       = sel_op;
          grant_id_d = win_id;
          cnt_d      = SETTLE_LOAD;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = norm_result;
          dz_d     = norm_dz;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_done) begin
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset drops any in-flight
  // operation and re-arms the arbiter so that requester 0 wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      op_q         <= 2'b00;
      cnt_q        <= 4'd0;
      result_q     <= 16'h0000;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      dz_q         <= dz_d;
    end
  end

  // Output drive. The ALU always sees the operand registers, and the
  // response stays valid only for the granted requester while in RESP.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == S_RESP) begin
      rsp_valid[grant_id_q] = 1'b1;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = result_q;
  assign rsp_dz     = dz_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. It has two instances: one with SETTLE=1 and
// one with SETTLE=4. Each instance drives a behavioural ALU. That ALU puts junk
// in the upper byte for sub and returns 0xDEAD for a divide by zero, so the
// arbiter's normalisation is exercised.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance with SETTLE = 1 ----------------
  logic        rst1;
  logic [1:0]  req_valid1, req_ready1, rsp_valid1, rsp_ready1, alu_op1;
  logic [15:0] req_a1, req_b1, rsp_result1, alu_result1;
  logic [3:0]  req_op1;
  logic        rsp_dz1, busy1, grant_id1;
  logic [7:0]  alu_a1, alu_b1;

  alu_arbiter #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst1),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_op(req_op1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .rsp_dz(rsp_dz1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
    .busy(busy1), .grant_id(grant_id1)
  );

  // ---------------- instance with SETTLE = 4 ----------------
  logic        rst4;
  logic [1:0]  req_valid4, req_ready4, rsp_valid4, rsp_ready4, alu_op4;
  logic [15:0] req_a4, req_b4, rsp_result4, alu_result4;
  logic [3:0]  req_op4;
  logic        rsp_dz4, busy4, grant_id4;
  logic [7:0]  alu_a4, alu_b4;

  alu_arbiter #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst4),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_op(req_op4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_result(rsp_result4), .rsp_dz(rsp_dz4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_result4),
    .busy(busy4), .grant_id(grant_id4)
  );

  // Behavioural alu_top.
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
    logic signed [15:0] sa, sb, q, r, d;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      2'b00: alu_model = sa + sb;
      2'b01: begin d = sa - sb; alu_model = {8'hAA, d[7:0]}; end
      2'b10: alu_model = sa * sb;
      default: begin
        if (b == 8'd0) alu_model = 16'hDEAD;
        else begin
          q = sa / sb;
          r = sa % sb;
          alu_model = {q[7:0], r[7:0]};
        end
      end
    endcase
  endfunction

  assign alu_result1 = alu_model(alu_a1, alu_b1, alu_op1);
  assign alu_result4 = alu_model(alu_a4, alu_b4, alu_op4);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One operation on the SETTLE=1 instance, with the response accepted at once.
  task automatic do_op1(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [15:0] exp_res, input logic exp_dz);
    int k;
    bit seen;
    @(posedge clk); #1;
    if (r == 0) begin req_a1[7:0] = a; req_b1[7:0] = b; req_op1[1:0] = op; end
    else        begin req_a1[15:8] = a; req_b1[15:8] = b; req_op1[3:2] = op; end
    req_valid1 = (r == 0) ? 2'b01 : 2'b10;
    rsp_ready1 = req_valid1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ready1 != 2'b00) seen = 1;
    end
    check_val("accept_seen", 32'(seen), 32'd1);
    check_val("req_ready", 32'(req_ready1), 32'(req_valid1));
    @(posedge clk); #1;
    req_valid1 = 2'b00;
    @(negedge clk);
    check_val("exec_busy", 32'(busy1), 32'd1);
    check_val("exec_alu", {14'd0, alu_op1, alu_a1, alu_b1}, {14'd0, op, a, b});
    check_val("exec_grant", 32'(grant_id1), 32'(r));
    k = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      k++;
      if (rsp_valid1 != 2'b00) seen = 1;
    end
    check_val("rsp_latency", 32'(k), 32'd1);
    check_val("rsp_valid", 32'(rsp_valid1), (r == 0) ? 32'd1 : 32'd2);
    check_val("rsp_result", 32'(rsp_result1), 32'(exp_res));
    check_val("rsp_dz", 32'(rsp_dz1), 32'(exp_dz));
    $display("op r=%0d a=%h b=%h op=%0d -> result=%h dz=%0d", r, a, b, op, rsp_result1, rsp_dz1);
    @(negedge clk);
    check_val("rsp_pulse", 32'(rsp_valid1), 32'd0);
    check_val("idle_busy", 32'(busy1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nrsp, gexp, cnt1;
    logic g;
    rst1 = 1; rst4 = 1;
    req_valid1 = 2'b01; req_a1 = 0; req_b1 = 0; req_op1 = 0; rsp_ready1 = 0;
    req_valid4 = 2'b11; req_a4 = 0; req_b4 = 0; req_op4 = 0; rsp_ready4 = 0;
    repeat (2) @(negedge clk);
    // Reset values; req_ready is forced low even though requests are pending.
    check_val("rst_ready1", 32'(req_ready1), 32'd0);
    check_val("rst_ready4", 32'(req_ready4), 32'd0);
    check_val("rst_outs1", {rsp_valid1, rsp_result1, rsp_dz1, busy1, grant_id1},
              32'd0);
    check_val("rst_alu1", {14'd0, alu_op1, alu_a1, alu_b1}, 32'd0);
    req_valid1 = 2'b00; req_valid4 = 2'b00;
    @(posedge clk); #1;
    rst1 = 0; rst4 = 0;

    // Directed operations on SETTLE=1.
    do_op1(0, 8'd100, 8'd5, 2'b00, 16'h0069, 1'b0);
    do_op1(1, 8'h9C,  8'd5, 2'b01, 16'hFF97, 1'b0);
    do_op1(1, 8'd10,  8'd3, 2'b10, 16'h001E, 1'b0);
    do_op1(0, 8'h9C,  8'd5, 2'b11, 16'hEC00, 1'b0);
    do_op1(0, 8'd50,  8'd0, 2'b11, 16'h0000, 1'b1);

    // Tie: both requesters valid from reset; grants must alternate 0,1,0,1.
    @(posedge clk); #1;
    rst1 = 1;
    req_valid1 = 2'b11;
    req_a1 = {8'd7, 8'd7}; req_b1 = {8'd3, 8'd3}; req_op1 = {2'b10, 2'b00};
    rsp_ready1 = 2'b11;
    @(negedge clk);
    check_val("tie_rst_ready", 32'(req_ready1), 32'd0);
    @(posedge clk); #1;
    rst1 = 0;
    ngr = 0; nrsp = 0; g = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      @(negedge clk);
      if (req_ready1 != 2'b00) begin
        gexp = ngr % 2;
        check_val("tie_onehot", 32'(req_ready1), (gexp == 0) ? 32'd1 : 32'd2);
        g = req_ready1[1];
        ngr++;
      end
      if (rsp_valid1 != 2'b00) begin
        check_val("tie_rsp_valid", 32'(rsp_valid1), g ? 32'd2 : 32'd1);
        check_val("tie_rsp_result", 32'(rsp_result1), g ? 32'h0015 : 32'h000A);
        $display("tie rsp r=%0d result=%h", g, rsp_result1);
        nrsp++;
      end
    end
    check_val("tie_nrsp", 32'(nrsp), 32'd4);
    @(posedge clk); #1;
    req_valid1 = 2'b00;

    // SETTLE=4: tie grants requester 0 (-3*4), and the response is held while
    // rsp_ready stays low.
    @(posedge clk); #1;
    req_valid4 = 2'b11;
    req_a4 = {8'd1, 8'hFD}; req_b4 = {8'd2, 8'd4}; req_op4 = {2'b00, 2'b10};
    rsp_ready4 = 2'b00;
    @(negedge clk);
    check_val("s4_ready", 32'(req_ready4), 32'd1);
    @(posedge clk); #1;
    req_valid4 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("s4_exec_alu", {14'd0, alu_op4, alu_a4, alu_b4}, {14'd0, 2'b10, 8'hFD, 8'h04});
      check_val("s4_exec_ready", {req_ready4, rsp_valid4, 3'b000, busy4}, 32'd1);
    end
    rsp_ready4 = 2'b10;  // the non-granted bit must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("s4_hold", {rsp_valid4, req_ready4, rsp_result4}, {16'h0004, 16'hFFF4});
      check_val("s4_hold_dz", 32'(rsp_dz4), 32'd0);
    end
    $display("s4 op r=0 result=%h", rsp_result4);
    rsp_ready4 = 2'b01;
    @(negedge clk);
    check_val("s4_after", {rsp_valid4, req_ready4, 3'b000, busy4}, 32'h0020);
    rsp_ready4 = 2'b10;
    @(posedge clk); #1;
    req_valid4 = 2'b00;
    repeat (4) @(negedge clk);
    @(negedge clk);
    check_val("s4_r1_rsp", {rsp_valid4, grant_id4, rsp_result4}, {13'd0, 2'b10, 1'b1, 16'h0003});
    $display("s4 op r=1 result=%h", rsp_result4);
    // Requester 0 alone (2+2), so that last_grant becomes 0.
    req_valid4 = 2'b01; req_a4[7:0] = 8'd2; req_b4[7:0] = 8'd2; req_op4[1:0] = 2'b00;
    rsp_ready4 = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    req_valid4 = 2'b00;
    repeat (4) @(negedge clk);
    @(negedge clk);
    check_val("s4_r0_rsp", {rsp_valid4, rsp_result4}, {14'd0, 2'b01, 16'h0004});
    $display("s4 op r=0 result=%h", rsp_result4);
    // Requester 1 starts an operation; reset hits in its 2nd EXEC cycle.
    req_valid4 = 2'b10; req_a4[15:8] = 8'd9; req_b4[15:8] = 8'd9; req_op4[3:2] = 2'b01;
    @(posedge clk);
    @(posedge clk); #1;
    check_val("s4_r1_accepted", {grant_id4, busy4}, 32'd3);
    @(posedge clk); #1;
    rst4 = 1;
    req_valid4 = 2'b11;
    #1;
    check_val("s4_rst_outs", {rsp_valid4, req_ready4, rsp_dz4, busy4, grant_id4, rsp_result4},
              32'd0);
    check_val("s4_rst_alu", {14'd0, alu_op4, alu_a4, alu_b4}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("s4_rst_hold", {rsp_valid4, req_ready4}, 32'd0);
    end
    @(posedge clk); #1;
    rst4 = 0;
    rsp_ready4 = 2'b00;
    @(negedge clk);
    check_val("s4_tie_after_rst", 32'(req_ready4), 32'd1);
    cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid4[1]) cnt1++;
    end
    check_val("s4_dropped_rsp", 32'(cnt1), 32'd0);
    check_val("s4_r0_wait", 32'(rsp_valid4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
